imem_loader: RTL

//  Writer side of the instruction memory: receives a program as a byte stream and writes it into

---
 rtl/imem_loader_pkg.sv | 19 +
 rtl/imem_byte_packer.sv | 46 ++++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Purpose: shared types and constants for the instruction-memory loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_loader_pkg;

   // Loader phases. CSUM is only reachable when the checksum trailer is built in.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   localparam int LEN_BYTES  = 4;   // length field: word count, little-endian
   localparam int WORD_BYTES = 4;   // instruction word, little-endian

endpackage

// File: rtl/imem_byte_packer.sv
// Purpose: packs a little-endian byte stream into 32-bit words (byte0 -> word[7:0]).
// Latency: word_vld/word are combinational in the cycle the 4th byte is consumed.
// Backpressure: none; consumes whatever byte_vld presents, caller owns flow control.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          restart packing at byte 0 (new frame)
//   byte_vld     byte consumed this cycle
//   byte_dat     consumed byte
//   word_vld     this cycle's byte completes a word
//   word         completed word (valid with word_vld)
module imem_byte_packer
   import imem_loader_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clr,
   input  logic        byte_vld,
   input  logic [7:0]  byte_dat,
   output logic        word_vld,
   output logic [31:0] word
);

   localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

   logic [1:0]  cnt_q;
   // Holds the three earlier bytes of the word; the 4th is taken straight
   // from the input so the word is available without an extra cycle.
   logic [23:0] sr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 2'd0;
         sr_q  <= 24'd0;
      end else if (clr) begin
         cnt_q <= 2'd0;
      end else if (byte_vld) begin
         cnt_q <= cnt_q + 2'd1;
         sr_q  <= {byte_dat, sr_q[23:8]};
      end
   end

   assign word_vld = byte_vld && (cnt_q == LAST_BYTE);
   assign word     = {byte_dat, sr_q};

endmodule

// File: rtl/imem_loader.sv
// Purpose: writes a byte-streamed program image (length, words[, checksum]) into inst_mem, holding the core in reset.
// Latency: imem_we one cycle after a word's 4th byte; done/cpu_rst_n one cycle after entering DONE.
// Backpressure: s_ready high only while loading (LEN/DATA/CSUM); one byte per cycle at most.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start          pulse: begin a new load (ignored while busy)
//   s_valid/s_ready/s_data   byte stream in
//   imem_we/imem_waddr/imem_wdata   inst_mem write port (registered)
//   cpu_rst_n      core reset, released only after a successful load
//   busy/done/err  load status; done and err are sticky until the next start
//
// Build option: define IMEM_LOADER_CHKSUM_EN to require a 4-byte little-endian
// trailer equal to the sum of all image words (mod 2^32).
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 10,
   parameter int MAX_WORDS = (1 << ADDR_W)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [7:0]        s_data,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_waddr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_rst_n,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [ADDR_W:0] IDX_ONE  = 1;
   localparam logic [31:0]     MAX_LEN  = 32'(MAX_WORDS);

   state_t state_q, state_d;

   logic              take;
   logic              restart;
   logic              pk_vld;
   logic [31:0]       pk_word;
   logic [ADDR_W:0]   widx_q;   // next word index; one bit wider so N==MAX_WORDS fits
   logic [ADDR_W:0]   len_q;    // accepted image length in words
   logic              last_word;
   logic              len_zero;
   logic              len_big;
`ifdef IMEM_LOADER_CHKSUM_EN
   logic [31:0]       csum_q;
`endif

   assign busy    = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
   assign s_ready = busy;
   assign take    = s_valid && s_ready;

   // start only counts from a quiescent state; mid-load pulses are dropped.
   assign restart = start && ((state_q == IDLE) || (state_q == DONE) || (state_q == ERR));

   assign len_zero  = (pk_word == 32'd0);
   assign len_big   = (pk_word > MAX_LEN);
   assign last_word = ((widx_q + IDX_ONE) == len_q);

   imem_byte_packer u_packer (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr      (restart),
      .byte_vld (take),
      .byte_dat (s_data),
      .word_vld (pk_vld),
      .word     (pk_word)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) state_d = LEN;
         end
         LEN: begin
            if (pk_vld) begin
               if (len_zero) begin
`ifdef IMEM_LOADER_CHKSUM_EN
                  state_d = CSUM;   // an empty image still carries a (zero) trailer
`else
                  state_d = DONE;
`endif
               end else if (len_big) begin
                  state_d = ERR;
               end else begin
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (pk_vld && last_word) begin
`ifdef IMEM_LOADER_CHKSUM_EN
               state_d = CSUM;
`else
               state_d = DONE;
`endif
            end
         end
`ifdef IMEM_LOADER_CHKSUM_EN
         CSUM: begin
            if (pk_vld) state_d = (pk_word == csum_q) ? DONE : ERR;
         end
`endif
         DONE, ERR: begin
            if (start) state_d = LEN;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         widx_q     <= '0;
         len_q      <= '0;
         imem_we    <= 1'b0;
         imem_waddr <= '0;
         imem_wdata <= 32'd0;
         cpu_rst_n  <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
         csum_q     <= 32'd0;
`endif
      end else begin
         state_q <= state_d;
         imem_we <= 1'b0;
         if (restart) begin
            widx_q    <= '0;
            len_q     <= '0;
            cpu_rst_n <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
`ifdef IMEM_LOADER_CHKSUM_EN
            csum_q    <= 32'd0;
`endif
         end else begin
            // Only meaningful when in range; an oversize length goes to ERR and is never used.
            if ((state_q == LEN) && pk_vld) len_q <= pk_word[ADDR_W:0];

            if ((state_q == DATA) && pk_vld) begin
               imem_we    <= 1'b1;
               imem_waddr <= widx_q[ADDR_W-1:0];
               imem_wdata <= pk_word;
               widx_q     <= widx_q + IDX_ONE;
`ifdef IMEM_LOADER_CHKSUM_EN
               csum_q     <= csum_q + pk_word;
`endif
            end

            // Registered from the state so release lands after the final write pulse.
            if (state_q == DONE) begin
               done      <= 1'b1;
               cpu_rst_n <= 1'b1;
            end

            if ((state_d == ERR) && (state_q != ERR)) err <= 1'b1;
         end
      end
   end

endmodule
